// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus between the ALU sequencer
// (master) and the restoring divider (slave).
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via
// shift and two's-complement trial subtract, with a start/busy/done handshake.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // The stored remainder is WIDTH bits: after each restore R < D, so the
  // extra bit of the WIDTH+1 working value is always zero between steps.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_by_zero_reg;

  logic             accept;
  logic             divisor_zero;
  logic             last_step;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             busy;
  logic             done;

  assign accept       = bus.start && (state_reg != RUN);
  assign divisor_zero = (bus.divisor == '0);
  assign last_step    = (state_reg == RUN) && (count_reg == LAST_COUNT);

  // One restoring step: trial = R_shifted + ~{0,D} + 1, keep it if non-negative.
  always_comb begin
    r_shift  = {r_reg, q_reg[WIDTH-1]};
    trial    = r_shift + ~{1'b0, d_reg} + ONE;
    trial_ok = ~trial[WIDTH];
    r_step   = trial_ok ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_step   = {q_reg[WIDTH-2:0], trial_ok};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = divisor_zero ? FIN : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = FIN;
        end
      end
      FIN: begin
        if (bus.start) begin
          state_next = divisor_zero ? FIN : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg           <= '0;
      q_reg           <= '0;
      d_reg           <= '0;
      count_reg       <= '0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else if (accept) begin
      d_reg           <= bus.divisor;
      r_reg           <= '0;
      q_reg           <= bus.dividend;
      count_reg       <= '0;
      div_by_zero_reg <= divisor_zero;
      if (divisor_zero) begin
        quotient_reg  <= '1;
        remainder_reg <= bus.dividend;
      end
    end else if (state_reg == RUN) begin
      r_reg     <= r_step;
      q_reg     <= q_step;
      count_reg <= count_reg + 1'b1;
      if (last_step) begin
        quotient_reg  <= q_step;
        remainder_reg <= r_step;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule
